// File: rtl/regfile8_onehot_wr.sv
// regfile8_onehot_wr: 8-entry register bank with one-hot write select, error detection and two registered read ports
module regfile8_onehot_wr #(
  parameter int WIDTH   = 8,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [7:0]       wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_req,
  input  logic [2:0]       rd_addr_a,
  input  logic [2:0]       rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             rd_valid,
  input  logic             err_clr,
  output logic             onehot_err,
  output logic [7:0]       err_sel
);
  logic [WIDTH-1:0] regs [8];
  logic             onehot, legal, illegal;
  logic [WIDTH-1:0] nxt_a, nxt_b;
  // classify the write select; wr_en=0 means no write and no check
  always_comb begin
    onehot  = (wr_sel != '0) && ((wr_sel & (wr_sel - 8'd1)) == '0);
    legal   = wr_en && onehot;
    illegal = wr_en && !onehot;
  end
  // read data with write bypass; r0 pinned to zero when enabled
  always_comb begin
    nxt_a = (ZERO_R0 && rd_addr_a == 3'd0) ? '0 : (legal && wr_sel[rd_addr_a]) ? wr_data : regs[rd_addr_a];
    nxt_b = (ZERO_R0 && rd_addr_b == 3'd0) ? '0 : (legal && wr_sel[rd_addr_b]) ? wr_data : regs[rd_addr_b];
  end
  // register storage; a write to r0 is dropped when r0 is hardwired
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++)
        if (legal && wr_sel[i] && !(ZERO_R0 && i == 0)) regs[i] <= wr_data;
    end
  end
  // registered read ports; data holds while no request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_a <= '0;
      rd_data_b <= '0;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) begin
        rd_data_a <= nxt_a;
        rd_data_b <= nxt_b;
      end
    end
  end
  // sticky error; a new error beats a same-cycle clear and recaptures err_sel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      onehot_err <= 1'b0;
      err_sel    <= 8'h00;
    end else begin
      onehot_err <= illegal || (onehot_err && !err_clr);
      if (illegal && (!onehot_err || err_clr)) err_sel <= wr_sel;
      else if (err_clr) err_sel <= 8'h00;
    end
  end
endmodule

// File: tb/tb_regfile8_onehot_wr.sv
// tb_regfile8_onehot_wr: scoreboard bench for regfile8_onehot_wr
module tb_regfile8_onehot_wr;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_sel = '0;
  logic [7:0] wr_data = '0;
  logic       rd_req = 1'b0;
  logic [2:0] rd_addr_a = '0;
  logic [2:0] rd_addr_b = '0;
  logic [7:0] rd_data_a, rd_data_b;
  logic       rd_valid;
  logic       err_clr = 1'b0;
  logic       onehot_err;
  logic [7:0] err_sel;
  int         passed = 0;
  int         total = 0;
  logic [15:0] q [$];

  regfile8_onehot_wr #(.WIDTH(8), .ZERO_R0(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .rd_valid(rd_valid),
    .err_clr(err_clr), .onehot_err(onehot_err), .err_sel(err_sel)
  );

  always #5 clk = ~clk;

  // monitor: every valid read must match the oldest expected pair
  always @(negedge clk) begin
    if (rd_valid) begin
      total++;
      if (q.size() == 0) begin
        $display("FAIL rd_unexpected: rd_valid=1 with a=%h b=%h, required no valid", rd_data_a, rd_data_b);
      end else begin
        logic [15:0] e;
        e = q.pop_front();
        if ({rd_data_a, rd_data_b} === e) passed++;
        else $display("FAIL rd_data: got a=%h b=%h, required a=%h b=%h", rd_data_a, rd_data_b, e[15:8], e[7:0]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h, required %h", name, got, exp);
  endtask

  task automatic rd(input logic [2:0] a, input logic [2:0] b, input logic [7:0] ea, input logic [7:0] eb);
    rd_req = 1'b1;
    rd_addr_a = a;
    rd_addr_b = b;
    q.push_back({ea, eb});
  endtask

  task automatic wr(input logic [7:0] sel, input logic [7:0] d);
    wr_en = 1'b1;
    wr_sel = sel;
    wr_data = d;
  endtask

  task automatic idle();
    wr_en = 1'b0;
    rd_req = 1'b0;
    err_clr = 1'b0;
  endtask

  initial begin
    #2;
    chk("reset_rd_a", {8'h0, rd_data_a}, 16'h0);
    chk("reset_rd_valid", {15'h0, rd_valid}, 16'h0);
    chk("reset_err", {7'h0, onehot_err, err_sel}, 16'h0);
    step();
    rst_n = 1'b1;
    rd(3'd3, 3'd5, 8'h00, 8'h00);
    step(); idle();
    chk("err_after_reset", {15'h0, onehot_err}, 16'h0);
    wr(8'h08, 8'hA5);
    step(); idle();
    wr(8'h04, 8'h5A);
    step(); idle();
    rd(3'd3, 3'd3, 8'hA5, 8'hA5);
    step(); idle();
    wr(8'h40, 8'h3C);
    rd(3'd6, 3'd2, 8'h3C, 8'h5A);
    step(); idle();
    wr(8'h0C, 8'hFF);
    step(); idle();
    chk("err_first", {7'h0, onehot_err, err_sel}, {7'h0, 1'b1, 8'h0C});
    wr(8'h00, 8'hEE);
    step(); idle();
    wr(8'h0C, 8'h77);
    rd(3'd2, 3'd3, 8'h5A, 8'hA5);
    step(); idle();
    chk("err_kept", {7'h0, onehot_err, err_sel}, {7'h0, 1'b1, 8'h0C});
    wr(8'h30, 8'h99);
    err_clr = 1'b1;
    step(); idle();
    chk("err_set_wins", {7'h0, onehot_err, err_sel}, {7'h0, 1'b1, 8'h30});
    err_clr = 1'b1;
    step(); idle();
    chk("err_cleared", {7'h0, onehot_err, err_sel}, 16'h0);
    rd(3'd4, 3'd5, 8'h00, 8'h00);
    step();
    rd(3'd6, 3'd3, 8'h3C, 8'hA5);
    step(); idle();
    wr(8'h01, 8'hFF);
    rd(3'd0, 3'd0, 8'h00, 8'h00);
    step(); idle();
    chk("r0_no_err", {15'h0, onehot_err}, 16'h0);
    rd(3'd0, 3'd3, 8'h00, 8'hA5);
    step(); idle();
    wr_sel = 8'hFF;
    step(); idle();
    chk("wr_en0_no_err", {15'h0, onehot_err}, 16'h0);
    wr(8'h80, 8'h11);
    step(); idle();
    rd(3'd7, 3'd7, 8'h11, 8'h11);
    step(); idle();
    step();
    rd_req = 1'b1;
    rd_addr_a = 3'd7;
    rd_addr_b = 3'd7;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_data", {rd_data_a, rd_data_b}, 16'h0);
    chk("async_rst_valid", {15'h0, rd_valid}, 16'h0);
    step(); idle();
    chk("rst_no_valid", {15'h0, rd_valid}, 16'h0);
    rst_n = 1'b1;
    rd(3'd7, 3'd3, 8'h00, 8'h00);
    step(); idle();
    repeat (4) step();
    chk("queue_drained", 16'(q.size()), 16'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/regfile8_onehot_wr.md
Name: regfile8_onehot_wr

Overview:
- 8-entry register bank directly downstream of the CPU 3-to-8 write-select decoder.
- Consumes the decoder's one-hot write select and provides two registered read ports addressed by 3-bit indices.
- Detects malformed (non-one-hot) write selects, blocks the write and flags the error.
- Sits between the decode stage and the ALU operand fetch.

Parameters:
- WIDTH, 8, data width of each register.
- ZERO_R0, 1, when 1 register 0 reads as 0 and writes to it are silently discarded; when 0 register 0 is a normal register.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  write strobe, qualifies wr_sel/wr_data for one cycle.
- wr_sel  input  8  one-hot register write select, bit i selects register i.
- wr_data  input  WIDTH  write data.
- rd_req  input  1  read request, samples rd_addr_a/rd_addr_b.
- rd_addr_a  input  3  read port A register index.
- rd_addr_b  input  3  read port B register index.
- rd_data_a  output  WIDTH  registered port A data.
- rd_data_b  output  WIDTH  registered port B data.
- rd_valid  output  1  high for one cycle when rd_data_a/b are updated.
- err_clr  input  1  clears the sticky error flag.
- onehot_err  output  1  sticky flag: wr_en was seen with a non-one-hot wr_sel.
- err_sel  output  8  wr_sel value captured at the first error since the last clear.

Behaviour:
- Reset (rst_n low, async, no clock needed):
  - All 8 registers are 0.
  - rd_data_a, rd_data_b, rd_valid, onehot_err are 0; err_sel is 8'h00.
  - Takes effect immediately and wins over any in-flight write or read; a read requested in the reset cycle produces no rd_valid.
- Write legality:
  - Legal: wr_en=1 and exactly one bit of wr_sel set.
  - All-zero and multi-bit selects are illegal.
- Legal write: the selected register takes wr_data at the next edge.
  - Exception: with ZERO_R0=1 and wr_sel=8'h01, no state changes and no error is raised.
- Illegal write: no register changes and onehot_err is set at the next edge.
  - err_sel is captured only if onehot_err was 0 before that edge; later errors do not overwrite it.
- wr_en=0: wr_sel is ignored entirely; no error checking.
- Error clear:
  - err_clr=1 clears onehot_err and err_sel at the next edge.
  - If an illegal write occurs in the same cycle, set wins: onehot_err stays 1 and err_sel takes the new wr_sel.
- Read timing: rd_req=1 in cycle N gives rd_data_a/b and rd_valid=1 in cycle N+1.
  - rd_valid is a single-cycle pulse per request.
  - Back-to-back requests give back-to-back valid cycles.
  - Data outputs hold their last value when rd_valid=0.
- Write-to-read bypass: a legal write in the same cycle as rd_req to a matching index returns wr_data, i.e. the new value.
  - An illegal write does not bypass; the read returns the stored value.
  - Both ports may hit the same register; each is bypassed independently.
- Register 0 with ZERO_R0=1: reads of index 0 return 0 regardless of a bypass attempt.
- No arithmetic is performed; data is stored and returned at WIDTH bits unchanged.

Test Plan:
- Reset release, rd_req with A=3, B=5 -> next cycle rd_valid=1 and rd_data_a = rd_data_b = 0; onehot_err=0.
- Write 8'hA5 with wr_sel=8'h08, then rd_req A=3, B=3 -> rd_data_a = rd_data_b = 8'hA5 one cycle after the request.
- Same cycle: wr_en with wr_sel=8'h40 and data 8'h3C, plus rd_req A=6, B=2 -> next cycle rd_data_a=8'h3C (bypass), rd_data_b = old r2.
- wr_en with wr_sel=8'h0C, then wr_sel=8'h00 -> onehot_err=1, err_sel=8'h0C (first error kept); registers 2 and 3 unchanged.
- Next, wr_en with wr_sel=8'h30 and err_clr=1 in the same cycle -> onehot_err remains 1, err_sel=8'h30. Then err_clr alone -> onehot_err=0, err_sel=8'h00.
- ZERO_R0=1: write 8'hFF with wr_sel=8'h01 plus same-cycle rd_req A=0 -> rd_data_a=0 and no error. Then assert rst_n low mid-sequence after writing r7=8'h11 -> outputs zero immediately and r7 reads 0 after release.
